spart_fifo: RTL and testbench
=============================

// Module: spart_fifo
// PURPOSE
//  Parametrised SPART successor: 8N1 UART with programmable 16x baud generator
//  and TX/RX FIFOs, exposed on the iocs/iorw/ioaddr/databus processor bus.
//  Sits between the CPU bus and the board txd/rxd pins. Adds buffering,
//  sticky error flags and an extended status register.
// PARAMETERS
//  TX_DEPTH   8        TX FIFO entries; power of 2, 2..64
//  RX_DEPTH   8        RX FIFO entries; power of 2, 2..64
//  DIV_RESET  16'd325  Baud divisor after reset: 50 MHz, 16x, 9600 baud
// PORTS
//  clk      in     1  System clock
//  rst      in     1  Asynchronous, active-low reset
//  iocs     in     1  Chip select
//  iorw     in     1  1 = read, 0 = write
//  ioaddr   in     2  00 data, 01 status, 10 divisor low, 11 divisor high
//  databus  inout  8  Driven by the block only when iocs & iorw, else 8'hzz
//  rda      out    1  RX FIFO not empty
//  tbr      out    1  TX FIFO not full
//  txd      out    1  Serial out; idle high
//  rxd      in     1  Serial in; asynchronous
// BEHAVIOUR
//  Reset (rst=0): FIFOs empty; divisor = DIV_RESET; txd=1; rda=0; tbr=1;
//   all flags 0; both FSMs IDLE.
//  Bus writes occur on the clk edge while iocs & ~iorw:
//   00 pushes into TX FIFO. A write to a full FIFO is dropped and sets nothing.
//   10/11 write the divisor low/high byte and reload the baud counter.
//  Bus reads are combinational while iocs & iorw:
//   00 returns RX head and pops once on that edge. Empty FIFO returns 8'h00, no pop.
//   01 returns {2'b0, frm_err, par_err, ovr, tx_idle, tbr, rda}. The read
//    clears ovr, par_err and frm_err on that edge.
//   10/11 return the divisor bytes.
//  Baud: down-counter reloads with max(div,1) and emits a 1-clk tick at 0.
//   One bit time is 16 ticks.
//  TX FSM IDLE->START->DATA(8, LSB first)->[PARITY]->STOP->IDLE:
//   - Leaves IDLE on the first tick with the FIFO non-empty; pops on that edge.
//   - STOP continues directly into START if more data is queued (no idle gap).
//   - tx_idle = FIFO empty & FSM in IDLE.
//  RX path:
//   - rxd passes through a 2-flop synchroniser.
//   - A falling edge in IDLE enters START; the line is re-sampled at tick 8.
//     If it is high the start was false: return to IDLE.
//   - Data is sampled every 16 ticks thereafter.
//   - STOP sampled 0: frame discarded, frm_err=1.
//   - Good frame with RX FIFO full: frame discarded, ovr=1.
//   - Push and pop in the same cycle with the FIFO full: pop first, push accepted.
//  Simultaneous TX push and pop: both take effect; count unchanged.
//  Pointers wrap modulo depth. count width = clog2(DEPTH)+1.
//  Divisor write mid-frame: takes effect at once; the frame in flight may be
//   corrupted (no protection required).
//  rst asserted mid-frame: immediate return to reset state; txd=1 asynchronously.
// CONFIGURATION
//  SPART_PARITY_EN defined:
//   - Even parity bit is sent after D7 and checked on receive.
//   - A mismatched frame is still pushed, and par_err=1.
//   - Frame is 11 bits.
//  SPART_PARITY_EN undefined:
//   - 8N1, 10-bit frame.
//   - No PARITY state; par_err reads 0.
// TESTING
//  1. Reset, read 01 -> 8'h06 (tbr=1, tx_idle=1); read 10/11 -> 8'h45/8'h01.
//  2. div=1, write 8'hA5 -> txd low 16 ticks, then bits 1,0,1,0,0,1,0,1, stop 1;
//     frame = 160 ticks (176 with parity).
//  3. Loop txd->rxd, div=1, write 8'h3C,8'hC3 -> rda=1; reads return 3C then C3;
//     rda=0; no gap between frames.
//  4. Write TX_DEPTH+1 bytes while TX is stalled -> tbr=0 after TX_DEPTH
//     writes; the extra byte is dropped.
//  5. Inject RX_DEPTH+1 frames without reading -> ovr=1; status read clears it;
//     the FIFO keeps the first RX_DEPTH bytes.
//  6. Send a frame with stop=0 -> frm_err=1, rda stays 0.
//     A 4-tick low glitch -> no frame.

Source files
------------

// File: rtl/spart_fifo.sv
// spart_fifo -- 8N1 UART with a programmable 16x baud generator and TX/RX
// FIFOs, attached to the iocs/iorw/ioaddr/databus processor bus.
//
// Optional feature macro: SPART_PARITY_EN
//   defined   : 11-bit frame with an even parity bit after D7, checked on receive
//   undefined : plain 8N1, 10-bit frame, par_err always reads 0
//
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   iocs     chip select
//   iorw     1 = read, 0 = write
//   ioaddr   00 data, 01 status, 10 divisor low, 11 divisor high
//   databus  bidirectional data; driven only while iocs & iorw
//   rda      RX FIFO not empty
//   tbr      TX FIFO not full
//   txd      serial out, idle high
//   rxd      serial in, asynchronous to clk
//
// Status byte: {2'b0, frm_err, par_err, ovr, tx_idle, tbr, rda}
//
// state    | meaning
// S_IDLE   | line idle / waiting for data (TX) or a start edge (RX)
// S_START  | start bit
// S_DATA   | eight data bits, LSB first
// S_PARITY | even parity bit (SPART_PARITY_EN only)
// S_STOP   | stop bit
module spart_fifo #(
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0]   TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]   RX_FULL = (RAW+1)'(RX_DEPTH);
  localparam logic [TAW-1:0] TP_INC  = (TAW)'(1);
  localparam logic [RAW-1:0] RP_INC  = (RAW)'(1);
  localparam logic [TAW:0]   TC_INC  = (TAW+1)'(1);
  localparam logic [RAW:0]   RC_INC  = (RAW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SPART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // ---------------------------------------------------------------- bus
  logic        w_wr, w_rd, w_tx_wr, w_rx_rd, w_stat_rd, w_div_wr;
  logic [15:0] w_div_new;
  logic [7:0]  w_rdata, w_status;
  logic        w_par_err, w_tx_idle;

  logic [15:0] r_div;
  logic [15:0] r_baud_cnt;
  logic        w_tick;

  assign w_wr      = iocs & ~iorw;
  assign w_rd      = iocs & iorw;
  assign w_tx_wr   = w_wr & (ioaddr == 2'b00);
  assign w_div_wr  = w_wr & ioaddr[1];
  assign w_rx_rd   = w_rd & (ioaddr == 2'b00);
  assign w_stat_rd = w_rd & (ioaddr == 2'b01);
  assign w_div_new = ioaddr[0] ? {databus, r_div[7:0]} : {r_div[15:8], databus};

  // ------------------------------------------------------------- TX FIFO
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TAW-1:0] r_tx_wptr, r_tx_rptr;
  logic [TAW:0]   r_tx_cnt;
  logic           w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [7:0]     w_tx_head;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == TX_FULL);
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  // a pop in the same cycle frees the slot, so a full-FIFO write still lands
  assign w_tx_push  = w_tx_wr & (~w_tx_full | w_tx_pop);

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= databus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TP_INC;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TP_INC;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TC_INC;
        2'b01:   r_tx_cnt <= r_tx_cnt - TC_INC;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------- RX FIFO
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [RAW-1:0] r_rx_wptr, r_rx_rptr;
  logic [RAW:0]   r_rx_cnt;
  logic           w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_good;
  logic [7:0]     w_rx_head;
  logic [7:0]     r_rx_shift;

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_FULL);
  assign w_rx_head  = r_rx_mem[r_rx_rptr];
  assign w_rx_pop   = w_rx_rd & ~w_rx_empty;
  assign w_rx_push  = w_rx_good & (~w_rx_full | w_rx_pop);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RP_INC;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RP_INC;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RC_INC;
        2'b01:   r_rx_cnt <= r_rx_cnt - RC_INC;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // --------------------------------------------------- divisor and baud
  // Tick period is max(div,1)+1 clocks; a divisor write restarts the count.
  assign w_tick = (r_baud_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div      <= DIV_RESET;
      r_baud_cnt <= (DIV_RESET == 16'd0) ? 16'd1 : DIV_RESET;
    end else begin
      if (w_div_wr) begin
        r_div      <= w_div_new;
        r_baud_cnt <= (w_div_new == 16'd0) ? 16'd1 : w_div_new;
      end else if (w_tick) begin
        r_baud_cnt <= (r_div == 16'd0) ? 16'd1 : r_div;
      end else begin
        r_baud_cnt <= r_baud_cnt - 16'd1;
      end
    end
  end

  // -------------------------------------------------------------- TX FSM
  state_e     r_tx_state;
  logic [3:0] r_tx_tcnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic       r_txd;
`ifdef SPART_PARITY_EN
  logic       r_tx_par;
`endif

  // pop when leaving IDLE, or at the end of STOP to chain straight into START
  assign w_tx_pop = w_tick & ~w_tx_empty &
                    ((r_tx_state == S_IDLE) |
                     ((r_tx_state == S_STOP) & (r_tx_tcnt == 4'd15)));
  assign w_tx_idle = w_tx_empty & (r_tx_state == S_IDLE);
  assign txd       = r_txd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_tcnt  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_txd      <= 1'b1;
`ifdef SPART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else if (w_tick) begin
      r_tx_tcnt <= r_tx_tcnt + 4'd1;
      case (r_tx_state)
        S_IDLE: begin
          r_tx_tcnt <= 4'd0;
          if (!w_tx_empty) begin
            r_tx_state <= S_START;
            r_txd      <= 1'b0;
            r_tx_shift <= w_tx_head;
`ifdef SPART_PARITY_EN
            r_tx_par   <= ^w_tx_head;
`endif
          end
        end
        S_START: begin
          if (r_tx_tcnt == 4'd15) begin
            r_tx_state <= S_DATA;
            r_tx_bit   <= 3'd0;
            r_txd      <= r_tx_shift[0];
          end
        end
        S_DATA: begin
          if (r_tx_tcnt == 4'd15) begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            if (r_tx_bit == 3'd7) begin
`ifdef SPART_PARITY_EN
              r_tx_state <= S_PARITY;
              r_txd      <= r_tx_par;
`else
              r_tx_state <= S_STOP;
              r_txd      <= 1'b1;
`endif
            end else begin
              r_txd <= r_tx_shift[1];
            end
          end
        end
`ifdef SPART_PARITY_EN
        S_PARITY: begin
          if (r_tx_tcnt == 4'd15) begin
            r_tx_state <= S_STOP;
            r_txd      <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_tx_tcnt == 4'd15) begin
            if (!w_tx_empty) begin
              r_tx_state <= S_START;
              r_txd      <= 1'b0;
              r_tx_shift <= w_tx_head;
`ifdef SPART_PARITY_EN
              r_tx_par   <= ^w_tx_head;
`endif
            end else begin
              r_tx_state <= S_IDLE;
            end
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- RX FSM
  state_e     r_rx_state;
  logic [3:0] r_rx_tcnt;
  logic [2:0] r_rx_bit;
  logic       r_rx_s1, r_rx_s2, r_rx_prev;
  logic       w_rx_done;
`ifdef SPART_PARITY_EN
  logic       r_rx_pbit;
`endif

  assign w_rx_done = w_tick & (r_rx_state == S_STOP) & (r_rx_tcnt == 4'd15);
  assign w_rx_good = w_rx_done & r_rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_tcnt  <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
`ifdef SPART_PARITY_EN
      r_rx_pbit  <= 1'b0;
`endif
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: begin
          if (r_rx_prev & ~r_rx_s2) begin
            r_rx_state <= S_START;
            r_rx_tcnt  <= 4'd0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            // mid start bit: a high line here means it was only a glitch
            if (r_rx_tcnt == 4'd7) begin
              if (r_rx_s2) begin
                r_rx_state <= S_IDLE;
              end else begin
                r_rx_state <= S_DATA;
                r_rx_tcnt  <= 4'd0;
                r_rx_bit   <= 3'd0;
              end
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd15) begin
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
              r_rx_bit   <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'd7) begin
`ifdef SPART_PARITY_EN
                r_rx_state <= S_PARITY;
`else
                r_rx_state <= S_STOP;
`endif
              end
            end
          end
        end
`ifdef SPART_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd15) begin
              r_rx_pbit  <= r_rx_s2;
              r_rx_state <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            // back to IDLE at mid stop so a following start edge is not missed
            if (r_rx_tcnt == 4'd15) r_rx_state <= S_IDLE;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------- sticky flags
  // A new event in the same cycle as a status read wins over the clear.
  logic r_ovr, r_frm_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr     <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_ovr     <= (w_rx_good & w_rx_full & ~w_rx_pop) | (r_ovr & ~w_stat_rd);
      r_frm_err <= (w_rx_done & ~r_rx_s2) | (r_frm_err & ~w_stat_rd);
    end
  end

`ifdef SPART_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= (w_rx_good & ((^r_rx_shift) ^ r_rx_pbit)) | (r_par_err & ~w_stat_rd);
    end
  end

  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  // ------------------------------------------------------------ readback
  assign rda      = ~w_rx_empty;
  assign tbr      = ~w_tx_full;
  assign w_status = {2'b00, r_frm_err, w_par_err, r_ovr, w_tx_idle, tbr, rda};

  always_comb begin
    w_rdata = 8'h00;
    case (ioaddr)
      2'b00:   w_rdata = w_rx_empty ? 8'h00 : w_rx_head;
      2'b01:   w_rdata = w_status;
      2'b10:   w_rdata = r_div[7:0];
      default: w_rdata = r_div[15:8];
    endcase
  end

  assign databus = w_rd ? w_rdata : 8'hzz;

endmodule

// File: tb/tb_spart_fifo.sv
// Bench for spart_fifo: bus reads and serial txd bits are queued as expected
// values by the stimulus and checked by independent monitor processes.
module tb_spart_fifo;

  localparam int TXD = 8;
  localparam int RXD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] tb_wdata = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] databus;
  logic       rda, tbr, txd;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd_w;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_rd_exp [$];
  string      q_rd_name [$];
  logic       q_bit_exp [$];

  assign databus = tb_drv ? tb_wdata : 8'hzz;
  assign rxd_w   = loop_en ? txd : rxd_drv;

  spart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_RESET(16'd325)) dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .rda    (rda),
    .tbr    (tbr),
    .txd    (txd),
    .rxd    (rxd_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 8'h%02h, required 8'h%02h", nm, act, exp);
    end
  endtask

  // bus read monitor
  always @(negedge clk) begin
    if (iocs && iorw) begin
      if (q_rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 8'h%02h, required no read", databus);
      end else begin
        check(q_rd_name.pop_front(), databus, q_rd_exp.pop_front());
      end
    end
  end

  // serial txd monitor: samples mid-bit (div=1 -> 32 clocks per bit)
  initial begin
    forever begin
      @(negedge txd);
      if (q_bit_exp.size() != 0) begin
        repeat (16) @(negedge clk);
        check("txd_bit", {7'b0, txd}, {7'b0, q_bit_exp.pop_front()});
        while (q_bit_exp.size() != 0) begin
          repeat (32) @(negedge clk);
          check("txd_bit", {7'b0, txd}, {7'b0, q_bit_exp.pop_front()});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_wdata = d; tb_drv = 1'b1;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    q_rd_exp.push_back(exp);
    q_rd_name.push_back(nm);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(posedge clk); #1;
    iocs = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] d);
    q_bit_exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) q_bit_exp.push_back(d[i]);
`ifdef SPART_PARITY_EN
    q_bit_exp.push_back(^d);
`endif
    q_bit_exp.push_back(1'b1);
  endtask

  task automatic bit_time();
    repeat (32) @(posedge clk);
    #1;
  endtask

  // frame layout: bit0 start, bits 8:1 data, bit9 parity, bit10 stop
  task automatic send_rx(input logic [7:0] d, input logic stop_b, input logic par_flip);
    logic [10:0] f;
    f = {stop_b, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
`ifndef SPART_PARITY_EN
      if (i == 9) continue;
`endif
      rxd_drv = f[i];
      bit_time();
    end
    rxd_drv = 1'b1;
  endtask

  task automatic wait_rda(input int budget, input string nm);
    int k;
    k = 0;
    while (!rda && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, {7'b0, rda}, 8'h01);
  endtask

  initial begin
    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", {7'b0, txd}, 8'h01);
    check("rst_rda", {7'b0, rda}, 8'h00);
    check("rst_tbr", {7'b0, tbr}, 8'h01);
    rst = 1'b1;
    bus_read(2'b01, 8'h06, "status_rst");
    bus_read(2'b10, 8'h45, "div_lo_rst");
    bus_read(2'b11, 8'h01, "div_hi_rst");
    bus_read(2'b00, 8'h00, "rx_empty_read");

    // single frame, div=1
    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, 8'h01, "div_lo_set");
    bus_read(2'b11, 8'h00, "div_hi_set");
    push_frame(8'hA5);
    bus_write(2'b00, 8'hA5);
    repeat (400) @(negedge clk);
    bus_read(2'b01, 8'h06, "status_after_tx");

    // loopback, two back-to-back frames
    loop_en = 1'b1;
    push_frame(8'h3C);
    push_frame(8'hC3);
    bus_write(2'b00, 8'h3C);
    bus_write(2'b00, 8'hC3);
    wait_rda(1000, "loop_rda");
    repeat (400) @(negedge clk);
    bus_read(2'b01, 8'h07, "status_loop");
    bus_read(2'b00, 8'h3C, "loop_byte0");
    bus_read(2'b00, 8'hC3, "loop_byte1");
    bus_read(2'b01, 8'h06, "status_loop_drained");
    loop_en = 1'b0;

    // TX stalled by a huge divisor: fill, overfill, then drain through loopback
    bus_write(2'b11, 8'hFF);
    bus_write(2'b10, 8'hFF);
    for (int i = 0; i < TXD; i++) begin
      bus_write(2'b00, 8'(8'h10 + i));
      if (i == TXD - 2) check("tbr_before_full", {7'b0, tbr}, 8'h01);
    end
    check("tbr_full", {7'b0, tbr}, 8'h00);
    bus_write(2'b00, 8'h99);
    bus_read(2'b01, 8'h00, "status_tx_full");
    loop_en = 1'b1;
    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    repeat (3200) @(negedge clk);
    bus_read(2'b01, 8'h07, "status_tx_drained");
    for (int i = 0; i < TXD; i++) bus_read(2'b00, 8'(8'h10 + i), "txfill_byte");
    bus_read(2'b01, 8'h06, "status_extra_dropped");
    loop_en = 1'b0;

    // RX overflow
    for (int i = 0; i <= RXD; i++) send_rx(8'(8'h40 + i), 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    bus_read(2'b01, 8'h0F, "status_ovr_set");
    bus_read(2'b01, 8'h07, "status_ovr_clr");
    for (int i = 0; i < RXD; i++) bus_read(2'b00, 8'(8'h40 + i), "ovr_keep_byte");
    bus_read(2'b01, 8'h06, "status_ovr_drained");

`ifdef SPART_PARITY_EN
    // bad parity: frame kept, par_err set
    send_rx(8'h81, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    bus_read(2'b01, 8'h17, "status_par_err");
    bus_read(2'b01, 8'h07, "status_par_clr");
    bus_read(2'b00, 8'h81, "par_frame_kept");
`endif

    // framing error, then a short low glitch
    send_rx(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("frm_rda", {7'b0, rda}, 8'h00);
    bus_read(2'b01, 8'h26, "status_frm_err");
    bus_read(2'b01, 8'h06, "status_frm_clr");
    rxd_drv = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_rda", {7'b0, rda}, 8'h00);
    bus_read(2'b01, 8'h06, "status_glitch");

    // reset in the middle of a frame
    bus_write(2'b00, 8'h00);
    repeat (100) @(negedge clk);
    check("txd_busy", {7'b0, txd}, 8'h00);
    rst = 1'b0;
    #1;
    check("txd_async_rst", {7'b0, txd}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    bus_read(2'b01, 8'h06, "status_after_rst");
    bus_read(2'b10, 8'h45, "div_lo_after_rst");

    repeat (4) @(negedge clk);
    check("txd_queue_drained", 8'(q_bit_exp.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
